// File: rtl/ex_operand_stage.sv
// ID/EX pipeline stage: latches decoded operands and controls, applies
// EX/MEM and MEM/WB forwarding combinationally, and presents ALU operands.
module ex_operand_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [15:0] id_imm,
   input  logic        id_sign_ext,
   input  logic        id_alu_src,
   input  logic [3:0]  id_alu_sel,
   input  logic        id_reg_write,
   input  logic        id_reg_dst,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_result,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic [3:0]  sel,
   output logic        ex_valid,
   output logic        ex_reg_write,
   output logic [4:0]  ex_rd,
   output logic [31:0] ex_store_data
);

   logic        valid_q;
   logic [31:0] rs_data_q;
   logic [31:0] rt_data_q;
   logic [4:0]  rs_q;
   logic [4:0]  rt_q;
   logic [4:0]  rd_q;
   logic [15:0] imm_q;
   logic        sign_ext_q;
   logic        alu_src_q;
   logic [3:0]  alu_sel_q;
   logic        reg_write_q;
   logic        reg_dst_q;

   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;
   logic [31:0] imm_ext;

   // Youngest producer (MEM) wins over WB; register 0 is never forwarded.
   function automatic logic [31:0] forward(
      input logic [4:0]  src,
      input logic [31:0] stored,
      input logic        m_we,
      input logic [4:0]  m_rd,
      input logic [31:0] m_res,
      input logic        w_we,
      input logic [4:0]  w_rd,
      input logic [31:0] w_res
   );
      logic [31:0] r;
      r = stored;
      if (src != 5'd0) begin
         if (m_we && (m_rd == src))
            r = m_res;
         else if (w_we && (w_rd == src))
            r = w_res;
      end
      return r;
   endfunction

   // Operand forwarding and immediate extension.
   always_comb begin
      rs_fwd  = forward(rs_q, rs_data_q, mem_reg_write, mem_rd, mem_result,
                        wb_reg_write, wb_rd, wb_result);
      rt_fwd  = forward(rt_q, rt_data_q, mem_reg_write, mem_rd, mem_result,
                        wb_reg_write, wb_rd, wb_result);
      imm_ext = {(sign_ext_q ? {16{imm_q[15]}} : 16'h0000), imm_q};
   end

   // Stage outputs; controls are masked while the stage holds a bubble.
   always_comb begin
      op1           = rs_fwd;
      op2           = alu_src_q ? imm_ext : rt_fwd;
      ex_store_data = rt_fwd;
      ex_valid      = valid_q;
      ex_reg_write  = valid_q & reg_write_q;
      sel           = valid_q ? alu_sel_q : 4'b0000;
      ex_rd         = reg_dst_q ? rd_q : rt_q;
   end

   // Stage register: rst > flush > stall (operand refresh) > load.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         sign_ext_q  <= 1'b0;
         alu_src_q   <= 1'b0;
         alu_sel_q   <= '0;
         reg_write_q <= 1'b0;
         reg_dst_q   <= 1'b0;
      end else if (flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
      end else if (stall) begin
         // Re-capture forwarded values so producers may retire while held.
         rs_data_q   <= rs_fwd;
         rt_data_q   <= rt_fwd;
      end else begin
         valid_q     <= id_valid;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         rs_q        <= id_rs;
         rt_q        <= id_rt;
         rd_q        <= id_rd;
         imm_q       <= id_imm;
         sign_ext_q  <= id_sign_ext;
         alu_src_q   <= id_alu_src;
         alu_sel_q   <= id_alu_sel;
         reg_write_q <= id_reg_write & id_valid;
         reg_dst_q   <= id_reg_dst;
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus pushes expected outputs
// from an instruction-level model; a negedge monitor pops and compares.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_sign_ext, id_alu_src, id_reg_write, id_reg_dst;
   logic [31:0] id_rs_data, id_rt_data, mem_result, wb_result;
   logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd;
   logic [15:0] id_imm;
   logic [3:0]  id_alu_sel;
   logic        stall, flush, mem_reg_write, wb_reg_write;
   logic [31:0] op1, op2, ex_store_data;
   logic [3:0]  sel;
   logic        ex_valid, ex_reg_write;
   logic [4:0]  ex_rd;

   ex_operand_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
      .id_sign_ext(id_sign_ext), .id_alu_src(id_alu_src), .id_alu_sel(id_alu_sel),
      .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst),
      .stall(stall), .flush(flush),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .op1(op1), .op2(op2), .sel(sel), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        rw;
      logic [3:0]  sel;
      logic        known;
      logic [4:0]  rd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] sd;
   } exp_t;

   exp_t q[$];
   int checks   = 0;
   int failures = 0;

   // Instruction held in EX, as the model sees it.
   typedef struct {
      logic        valid;
      logic        known;
      logic [31:0] a, b;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic        sx, use_imm, we, to_rd;
      logic [3:0]  op;
   } instr_t;

   instr_t m;
   bit     started = 0;

   function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
      if (r == 0) return v;
      if (mem_reg_write && mem_rd == r) return mem_result;
      if (wb_reg_write && wb_rd == r) return wb_result;
      return v;
   endfunction

   function automatic logic [31:0] m_ext(input logic [15:0] imm, input logic sx);
      int unsigned x;
      x = imm;
      if (sx && x >= 32768) x = x + 32'hFFFF0000;
      return x;
   endfunction

   // Push this cycle's expectation, then advance the model across the edge.
   task automatic step();
      exp_t e;
      if (started) begin
         e.v     = m.valid;
         e.rw    = m.valid && m.we;
         e.sel   = m.valid ? m.op : 4'b0000;
         e.known = m.known;
         e.rd    = m.to_rd ? m.rd : m.rt;
         e.op1   = m_fwd(m.rs, m.a);
         e.sd    = m_fwd(m.rt, m.b);
         e.op2   = m.use_imm ? m_ext(m.imm, m.sx) : e.sd;
         q.push_back(e);
      end
      @(posedge clk);
      if (rst) begin
         m = '{valid: 0, known: 1, a: 0, b: 0, rs: 0, rt: 0, rd: 0, imm: 0,
               sx: 0, use_imm: 0, we: 0, to_rd: 0, op: 0};
      end else if (flush) begin
         m.valid = 0; m.we = 0; m.known = 0;
      end else if (stall) begin
         m.a = m_fwd(m.rs, m.a);
         m.b = m_fwd(m.rt, m.b);
      end else begin
         m = '{valid: id_valid, known: id_valid, a: id_rs_data, b: id_rt_data,
               rs: id_rs, rt: id_rt, rd: id_rd, imm: id_imm, sx: id_sign_ext,
               use_imm: id_alu_src, we: id_reg_write, to_rd: id_reg_dst, op: id_alu_sel};
      end
      started = 1;
      #1;
   endtask

   task automatic idle();
      rst = 0; id_valid = 0; id_rs_data = 0; id_rt_data = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_sign_ext = 0;
      id_alu_src = 0; id_alu_sel = 0; id_reg_write = 0; id_reg_dst = 0;
      stall = 0; flush = 0; mem_reg_write = 0; mem_rd = 0; mem_result = 0;
      wb_reg_write = 0; wb_rd = 0; wb_result = 0;
   endtask

   task automatic load(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = 5'd9; id_rs_data = a; id_rt_data = b;
      id_alu_sel = op; id_reg_write = 1; id_reg_dst = 1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("ex_valid", {31'b0, ex_valid}, {31'b0, e.v});
            check("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, e.rw});
            check("sel", {28'b0, sel}, {28'b0, e.sel});
            if (e.known) begin
               check("ex_rd", {27'b0, ex_rd}, {27'b0, e.rd});
               check("op1", op1, e.op1);
               check("op2", op2, e.op2);
               check("ex_store_data", ex_store_data, e.sd);
            end
         end
      end
   end

   initial begin
      idle(); rst = 1;
      step();
      // Plain load, then observe.
      idle(); load(5'd1, 5'd2, 32'd10, 32'd11, 4'b0010); step();
      idle(); step();
      // Immediate sign/zero extension.
      idle(); load(5'd1, 5'd2, 32'd0, 32'd0, 4'b0010);
      id_imm = 16'hFFF0; id_sign_ext = 1; id_alu_src = 1; step();
      id_sign_ext = 0; step();
      idle(); step();
      // Forwarding priority, observed while stalled.
      idle(); load(5'd5, 5'd0, 32'd1, 32'd2, 4'b0001); step();
      idle(); stall = 1;
      mem_reg_write = 1; mem_rd = 5; mem_result = 12;
      wb_reg_write = 1; wb_rd = 5; wb_result = 13;
      step();
      idle(); load(5'd5, 5'd6, 32'd1, 32'd2, 4'b0001); step();
      idle(); stall = 1; wb_reg_write = 1; wb_rd = 5; wb_result = 13; step();
      idle(); load(5'd0, 5'd6, 32'd7, 32'd2, 4'b0001); step();
      idle(); stall = 1; mem_reg_write = 1; mem_rd = 0; mem_result = 55; step();
      // Stall refresh: WB producer retires during the stall.
      idle(); load(5'd3, 5'd4, 32'd1, 32'd2, 4'b0110); id_reg_dst = 0; step();
      idle(); stall = 1; wb_reg_write = 1; wb_rd = 4; wb_result = 99; step();
      idle(); stall = 1; step();
      idle(); step();
      // Flush, flush+stall, then reset during a valid NOR.
      idle(); load(5'd1, 5'd2, 32'd3, 32'd4, 4'b0110); flush = 1; step();
      idle(); load(5'd1, 5'd2, 32'd3, 32'd4, 4'b0110); flush = 1; stall = 1; step();
      idle(); load(5'd1, 5'd2, 32'd3, 32'd4, 4'b1100); step();
      idle(); stall = 1; rst = 1; step();
      idle(); step();
      // Randomized traffic with a small register range to hit forwarding often.
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 99) < 2);
         flush         = ($urandom_range(0, 99) < 8);
         stall         = ($urandom_range(0, 99) < 20);
         id_valid      = ($urandom_range(0, 99) < 85);
         id_rs_data    = $urandom;
         id_rt_data    = $urandom;
         id_rs         = 5'($urandom_range(0, 7));
         id_rt         = 5'($urandom_range(0, 7));
         id_rd         = 5'($urandom_range(0, 31));
         id_imm        = 16'($urandom);
         id_sign_ext   = 1'($urandom);
         id_alu_src    = 1'($urandom);
         id_alu_sel    = 4'($urandom);
         id_reg_write  = 1'($urandom);
         id_reg_dst    = 1'($urandom);
         mem_reg_write = 1'($urandom);
         mem_rd        = 5'($urandom_range(0, 7));
         mem_result    = $urandom;
         wb_reg_write  = 1'($urandom);
         wb_rd         = 5'($urandom_range(0, 7));
         wb_result     = $urandom;
         step();
      end
      idle();
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
